ram_io_responder: RTL

- Target side of the byte-serial memory bus driven by the memory controller (addr/dout/wr out, din back).
- Decodes each byte access to either a single-port byte RAM or a small memory-mapped I/O window.
- The I/O window holds a UART TX FIFO, a UART RX FIFO, a status register and a simulation-end register.
- Sits at the top level between the memory controller and the board RAM/UART pins.

---
 rtl/ram_io_responder_pkg.sv | 41 ++++
 rtl/ram_io_responder_if.sv | 14 +
 rtl/ram_io_responder_byte_fifo.sv | 50 +++++
 rtl/ram_io_responder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared constants and address decode for the RAM / memory-mapped I/O responder.
//   IO_UART_ADDR : UART data register (read pops RX, write pushes TX)
//   IO_STAT_ADDR : status (read) / simulation-end register (write)
//   STAT_*       : bit positions inside the status byte
//   IO_DEC_*     : address bits selecting the I/O window
package ram_io_responder_pkg;

  localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_STAT_ADDR = 32'h0003_0004;

  localparam int unsigned STAT_TX_FULL = 0;
  localparam int unsigned STAT_RX_NE   = 1;
  localparam int unsigned STAT_OVF     = 2;

  localparam int unsigned IO_DEC_HI  = 17;
  localparam int unsigned IO_DEC_LO  = 16;
  localparam logic [1:0]  IO_DEC_VAL = 2'b11;

  typedef enum logic [1:0] {
    SelRam,
    SelUart,
    SelStat,
    SelNone
  } io_sel_e;

  // Bits above IO_DEC_HI never take part in the decode.
  function automatic io_sel_e io_decode(input logic [IO_DEC_HI:0] addr);
    io_sel_e sel;
    if (addr[IO_DEC_HI:IO_DEC_LO] != IO_DEC_VAL) begin
      sel = SelRam;
    end else if (addr == IO_UART_ADDR[IO_DEC_HI:0]) begin
      sel = SelUart;
    end else if (addr == IO_STAT_ADDR[IO_DEC_HI:0]) begin
      sel = SelStat;
    end else begin
      sel = SelNone;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Byte-serial memory bus between the memory controller and the responder.
//   addr_i : byte address        (controller -> responder)
//   data_i : write byte          (controller -> responder)
//   wr_i   : 1 = write, 0 = read (controller -> responder)
//   data_o : read byte, 1 cycle after the read address (responder -> controller)
interface ram_io_responder_if;
  logic [31:0] addr_i;
  logic [7:0]  data_i;
  logic        wr_i;
  logic [7:0]  data_o;

  modport master (output addr_i, output data_i, output wr_i, input data_o);
  modport slave  (input addr_i, input data_i, input wr_i, output data_o);
endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte-wide synchronous FIFO, 2**FIFO_AW entries.
//   clk, rst  : clock, asynchronous active-low reset (empties the FIFO)
//   push, din : enqueue din; accepted when not full, or when full and popping
//   pop, dout : dequeue; dout is the head, combinational from storage
//   full/empty: occupancy flags from the extended pointers
module ram_io_responder_byte_fifo #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned       Depth  = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  PtrOne = 1;

  logic [7:0]       mem_q [Depth];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  assign pop_ok  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Target side of the byte-serial memory bus: decodes each access to a byte RAM or to a
// small I/O window holding UART TX/RX FIFOs, a status register and a sim-end register.
//   clk, rst            : clock, asynchronous active-low reset
//   bus (slave)         : addr_i / data_i / wr_i in, data_o out (1-cycle read latency)
//   tx_data, tx_valid   : TX FIFO head and non-empty; popped when tx_ready is high
//   rx_data, rx_valid   : bytes from the UART receiver; accepted while rx_ready is high
//   sim_end, sim_end_code : sticky end flag and last byte written to the end register
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned RAM_AW  = 17,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  ram_io_responder_if.slave         bus,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic                      sim_end,
  output logic [7:0]                sim_end_code
);

  localparam int unsigned RamDepth = 1 << RAM_AW;

  logic [7:0]        ram_q [RamDepth];
  io_sel_e           sel;
  logic [RAM_AW-1:0] ram_addr;
  logic              unused_addr;

  logic       rd_en, ram_wr, end_wr;
  logic       uart_rd, uart_rd_first, uart_rd_q;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_head, stat, data_d, data_q;
  logic       ovf_q, sim_end_q, rx_en_q;
  logic [7:0] code_q;

  assign sel         = io_decode(bus.addr_i[IO_DEC_HI:0]);
  assign ram_addr    = bus.addr_i[RAM_AW-1:0];
  assign unused_addr = ^bus.addr_i[31:IO_DEC_HI+1];

  assign rd_en   = !bus.wr_i;
  assign ram_wr  = bus.wr_i && (sel == SelRam);
  assign end_wr  = bus.wr_i && (sel == SelStat);
  assign tx_push = bus.wr_i && (sel == SelUart);
  assign tx_pop  = tx_valid && tx_ready;

  // A run of back-to-back reads of the UART register pops the RX FIFO only once.
  assign uart_rd       = rd_en && (sel == SelUart);
  assign uart_rd_first = uart_rd && !uart_rd_q;
  assign rx_pop        = uart_rd_first && !rx_empty;

  // rx_ready stays low until the first clock after reset release.
  assign rx_ready = rx_en_q && !rx_full;
  assign rx_push  = rx_valid && rx_ready;

  assign tx_valid     = !tx_empty;
  assign sim_end      = sim_end_q;
  assign sim_end_code = code_q;
  assign bus.data_o   = data_q;

  always_comb begin
    stat               = 8'h00;
    stat[STAT_TX_FULL] = tx_full;
    stat[STAT_RX_NE]   = !rx_empty;
    stat[STAT_OVF]     = ovf_q;
  end

  // data_o holds across write cycles and across repeated UART reads.
  always_comb begin
    data_d = data_q;
    if (rd_en) begin
      unique case (sel)
        SelRam:  data_d = ram_q[ram_addr];
        SelUart: if (uart_rd_first) data_d = rx_empty ? 8'h00 : rx_head;
        SelStat: data_d = stat;
        SelNone: data_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= 8'h00;
      uart_rd_q <= 1'b0;
      ovf_q     <= 1'b0;
      sim_end_q <= 1'b0;
      code_q    <= 8'h00;
      rx_en_q   <= 1'b0;
    end else begin
      data_q    <= data_d;
      uart_rd_q <= uart_rd;
      rx_en_q   <= 1'b1;
      if (tx_push && tx_full && !tx_pop) ovf_q <= 1'b1;
      if (end_wr) begin
        sim_end_q <= 1'b1;
        code_q    <= bus.data_i;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[ram_addr] <= bus.data_i;
  end

  ram_io_responder_byte_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus.data_i),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  ram_io_responder_byte_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule
